// File: rtl/bcd_calc_pkg.sv
// bcd_calc_pkg: shared digit type, display mode, active-low 7-segment patterns and digit helpers
package bcd_calc_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [1:0] {OPER, SUM, DIFF} mode_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [0:9][6:0] SEG_DIGIT = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    return d == 4'd9 ? 4'd0 : d + 4'd1;
  endfunction
  function automatic logic [6:0] seg_of(input bcd_digit_t d);
    return d > 4'd9 ? SEG_BLANK : SEG_DIGIT[d];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, DEB_CYCLES-sample level debouncer and one-cycle press pulse (clk, rst, btn -> pulse)
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEB_CYCLES);
  logic [1:0] sync;
  logic lvl;
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = sync[1] != lvl && cnt == CW'(DEB_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      lvl <= 1'b0;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      lvl <= hit ? sync[1] : lvl;
      cnt <= (sync[1] == lvl || hit) ? '0 : cnt + CW'(1);
      pulse <= hit & sync[1];
    end
endmodule

// File: rtl/bcd_calc_mux.sv
// bcd_calc_mux: BCD add/subtract calculator; debounced digit/swap/clr buttons in, multiplexed active-low segment/an out
module bcd_calc_mux
  import bcd_calc_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int SCAN_BITS = 15,
  parameter int DEB_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DIGITS-1:0] inc_btn,
  input  logic                op_add,
  input  logic                op_sub,
  input  logic                op_swap,
  input  logic                clr,
  output logic [6:0]          segment,
  output logic [2*DIGITS-1:0] an
);
  localparam int ND = 2 * DIGITS;
  localparam int KB = $clog2(ND);
  logic [ND-1:0] inc_p;
  logic swap_p, clr_p;
  bcd_digit_t [DIGITS-1:0] a, b, x, y, mag, mag_r;
  bcd_digit_t [DIGITS:0] sum, sum_r;
  bcd_digit_t [ND-1:0] oper, sum_pad, mag_pad;
  logic ge, neg_r, c, br;
  logic [4:0] ts, td;
  logic [SCAN_BITS-1:0] cnt;
  logic [KB-1:0] k;
  mode_t mode;
  logic [6:0] seg_n;
  logic [ND-1:0] an_n;
  for (genvar i = 0; i < ND; i++) begin : g_inc
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (.clk(clk), .rst(rst), .btn(inc_btn[i]), .pulse(inc_p[i]));
  end
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_swap (.clk(clk), .rst(rst), .btn(op_swap), .pulse(swap_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (.clk(clk), .rst(rst), .btn(clr), .pulse(clr_p));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a <= '0;
      b <= '0;
    end else if (clr_p) begin
      a <= '0;
      b <= '0;
    end else if (swap_p) begin
      a <= b;
      b <= a;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (inc_p[i]) b[i] <= bcd_inc(b[i]);
        if (inc_p[i+DIGITS]) a[i] <= bcd_inc(a[i]);
      end
    end
  assign ge = a >= b;
  always_comb begin
    c = 1'b0;
    br = 1'b0;
    ts = '0;
    td = '0;
    sum = '0;
    mag = '0;
    x = ge ? a : b;
    y = ge ? b : a;
    for (int i = 0; i < DIGITS; i++) begin
      ts = 5'(a[i]) + 5'(b[i]) + 5'(c);
      c = ts > 5'd9;
      sum[i] = c ? 4'(ts - 5'd10) : ts[3:0];
      td = 5'(x[i]) + 5'd10 - 5'(y[i]) - 5'(br);
      br = td < 5'd10;
      mag[i] = br ? td[3:0] : 4'(td - 5'd10);
    end
    sum[DIGITS] = 4'(c);
  end
  assign k = cnt[SCAN_BITS-1 -: KB];
  assign mode = op_add ? SUM : op_sub ? DIFF : OPER;
  assign oper = {a, b};
  assign sum_pad = (4*ND)'(sum_r);
  assign mag_pad = (4*ND)'(mag_r);
  always_comb begin
    seg_n = SEG_BLANK;
    an_n = '1;
    if (32'(k) < ND) begin
      an_n[k] = 1'b0;
      seg_n = mode == OPER ? seg_of(oper[k])
            : mode == SUM ? (32'(k) <= DIGITS ? seg_of(sum_pad[k]) : SEG_BLANK)
            : 32'(k) < DIGITS ? seg_of(mag_pad[k])
            : 32'(k) == DIGITS && neg_r ? SEG_MINUS : SEG_BLANK;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum_r <= '0;
      mag_r <= '0;
      neg_r <= 1'b0;
      cnt <= '0;
      segment <= SEG_BLANK;
      an <= '1;
    end else begin
      sum_r <= sum;
      mag_r <= mag;
      neg_r <= !ge;
      cnt <= cnt + SCAN_BITS'(1);
      segment <= seg_n;
      an <= an_n;
    end
endmodule

// File: tb/tb_bcd_calc_mux.sv
// tb_bcd_calc_mux: directed self-checking bench for bcd_calc_mux with hand-computed display patterns
module tb_bcd_calc_mux;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic op_add = 1'b0;
  logic op_sub = 1'b0;
  logic op_swap = 1'b0;
  logic clr = 1'b0;
  logic [3:0] inc_btn = '0;
  logic [6:0] segment;
  logic [3:0] an;
  int n_cmp = 0;
  int n_bad = 0;
  bcd_calc_mux #(.DIGITS(2), .SCAN_BITS(4), .DEB_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .inc_btn(inc_btn), .op_add(op_add), .op_sub(op_sub),
    .op_swap(op_swap), .clr(clr), .segment(segment), .an(an)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] sd(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BL;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic disp(input string tag, input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e [4];
    int w;
    e = '{e0, e1, e2, e3};
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (an !== ~(4'b1 << k) && w < 64) begin
        @(negedge clk);
        w++;
      end
      if (w == 64) chk($sformatf("%s_scan%0d", tag, k), 16'(an), 16'(~(4'b1 << k)));
      else chk($sformatf("%s_k%0d", tag, k), 16'(segment), 16'(e[k]));
    end
  endtask
  task automatic press(input logic [5:0] m, input int hold = 24);
    {clr, op_swap, inc_btn} = m;
    repeat (hold) @(negedge clk);
    {clr, op_swap, inc_btn} = '0;
    repeat (24) @(negedge clk);
  endtask
  task automatic load(input int a1, input int a0, input int b1, input int b0);
    logic [5:0] m;
    for (int n = 1; n <= 9; n++) begin
      m = {2'b00, a1 >= n, a0 >= n, b1 >= n, b0 >= n};
      if (m != 6'd0) press(m);
    end
  endtask
  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_an", 16'(an), 16'h000f);
    chk("rst_seg", 16'(segment), 16'(BL));
    rst = 1'b0;
    disp("zero", sd(0), sd(0), sd(0), sd(0));
    load(4, 7, 8, 5);
    disp("oper", sd(5), sd(8), sd(7), sd(4));
    op_add = 1'b1;
    disp("sum", sd(2), sd(3), sd(1), BL);
    op_add = 1'b0;
    op_sub = 1'b1;
    disp("diff_neg", sd(8), sd(3), MI, BL);
    op_add = 1'b1;
    disp("add_prio", sd(2), sd(3), sd(1), BL);
    op_add = 1'b0;
    press(6'b010000);
    disp("swap_diff", sd(8), sd(3), BL, BL);
    op_sub = 1'b0;
    disp("swap_oper", sd(7), sd(4), sd(5), sd(8));
    press(6'b100000);
    disp("clr", sd(0), sd(0), sd(0), sd(0));
    load(0, 0, 3, 9);
    disp("b39", sd(9), sd(3), sd(0), sd(0));
    press(6'b000001);
    disp("wrap", sd(0), sd(3), sd(0), sd(0));
    press(6'b000100, 80);
    disp("held", sd(0), sd(3), sd(1), sd(0));
    for (int i = 0; i < 14; i++) begin
      inc_btn[0] = ~inc_btn[0];
      repeat (14) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    disp("bounce", sd(0), sd(3), sd(1), sd(0));
    inc_btn[0] = 1'b1;
    repeat (19) @(negedge clk);
    inc_btn[0] = 1'b0;
    repeat (30) @(negedge clk);
    disp("hold19", sd(1), sd(3), sd(1), sd(0));
    press(6'b100100);
    disp("clr_inc", sd(0), sd(0), sd(0), sd(0));
    load(3, 3, 3, 3);
    op_sub = 1'b1;
    disp("eq_diff", sd(0), sd(0), BL, BL);
    op_sub = 1'b0;
    press(6'b010001);
    disp("swap_inc", sd(3), sd(3), sd(3), sd(3));
    inc_btn[0] = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_an", 16'(an), 16'h000f);
    chk("async_seg", 16'(segment), 16'(BL));
    inc_btn[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("scan_restart", 16'(an), 16'h000e);
    disp("post_rst", sd(0), sd(0), sd(0), sd(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
